// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use and HI/LO-occupancy stalls, branch flush, muldiv launch.
// Optional stall-cycle performance counter built only when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_ctrl #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        id_is_muldiv,
  input  logic        id_reads_hilo,
  input  logic        ex_MemRead,
  input  logic [4:0]  ex_WriteReg,
  input  logic        branch_taken,
  output logic        PCWrite,
  output logic        IFID_Write,
  output logic        IFID_flush,
  output logic        IDEX_bubble,
  output logic        muldiv_start,
  output logic        muldiv_busy,
  output logic        stall_out,
  output logic [15:0] stall_count
);

  localparam logic [5:0] MdLoad = 6'(MULDIV_CYCLES);

  logic [5:0] mdcnt;
  logic       loadUse;
  logic       hiloHazard;

  assign muldiv_busy = (mdcnt != 6'd0);

  assign loadUse = ex_MemRead && (ex_WriteReg != 5'd0) &&
                   ((ex_WriteReg == id_rs) || (id_uses_rt && (ex_WriteReg == id_rt)));

  assign hiloHazard = muldiv_busy && (id_reads_hilo || id_is_muldiv);

  // Flush outranks any stall: the ID instruction is being discarded anyway.
  always_comb begin
    PCWrite      = 1'b1;
    IFID_Write   = 1'b1;
    IFID_flush   = 1'b0;
    IDEX_bubble  = 1'b0;
    muldiv_start = 1'b0;
    stall_out    = 1'b0;
    if (Reset) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IFID_flush  = 1'b1;
      IDEX_bubble = 1'b1;
    end else if (branch_taken) begin
      IFID_flush  = 1'b1;
      IDEX_bubble = 1'b1;
    end else if (loadUse || hiloHazard) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_bubble = 1'b1;
      stall_out   = 1'b1;
    end else begin
      muldiv_start = id_is_muldiv;
    end
  end

  // Occupancy keeps draining through stalls and flushes.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mdcnt <= 6'd0;
    end else if (muldiv_start) begin
      mdcnt <= MdLoad;
    end else if (mdcnt != 6'd0) begin
      mdcnt <= mdcnt - 6'd1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stallCnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stallCnt <= 16'h0000;
    end else if (stall_out && (stallCnt != 16'hFFFF)) begin
      stallCnt <= stallCnt + 16'd1;
    end
  end

  assign stall_count = stallCnt;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl: driver pushes expected outputs, monitor pops and compares.
// Honours HAZARD_PERF_CNT_EN for the expected stall_count.
module tb_hazard_stall_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_WriteReg = '0;
  logic        id_uses_rt = 1'b0, id_is_muldiv = 1'b0, id_reads_hilo = 1'b0;
  logic        ex_MemRead = 1'b0, branch_taken = 1'b0;
  logic        PCWrite, IFID_Write, IFID_flush, IDEX_bubble;
  logic        muldiv_start, muldiv_busy, stall_out;
  logic [15:0] stall_count;

  hazard_stall_ctrl #(.MULDIV_CYCLES(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo),
    .ex_MemRead(ex_MemRead), .ex_WriteReg(ex_WriteReg), .branch_taken(branch_taken),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_flush(IFID_flush),
    .IDEX_bubble(IDEX_bubble), .muldiv_start(muldiv_start), .muldiv_busy(muldiv_busy),
    .stall_out(stall_out), .stall_count(stall_count)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  // Expected control bits, ordered {PCWrite, IFID_Write, IFID_flush, IDEX_bubble, muldiv_start, muldiv_busy, stall_out}
  localparam logic [6:0] NORM = 7'b1100000;
  localparam logic [6:0] NRBZ = 7'b1100010;
  localparam logic [6:0] STRT = 7'b1100100;
  localparam logic [6:0] LUST = 7'b0001001;
  localparam logic [6:0] HHST = 7'b0001011;
  localparam logic [6:0] FLSH = 7'b1111000;
  localparam logic [6:0] FLBZ = 7'b1111010;
  localparam logic [6:0] RSTO = 7'b0011000;

  logic [22:0] exp_q[$];
  int          id_q[$];
  int          checks = 0;
  int          errors = 0;
  int          vec_no = 0;
  logic [15:0] exp_cnt = 16'h0000;

  // driver: one vector per cycle, applied just after the rising edge
  task automatic vec(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urt, input logic md, input logic rh,
                     input logic mr, input logic [4:0] wr, input logic br,
                     input logic [6:0] e);
    @(posedge Clk);
    #1;
    Reset = rst; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    id_is_muldiv = md; id_reads_hilo = rh;
    ex_MemRead = mr; ex_WriteReg = wr; branch_taken = br;
`ifdef HAZARD_PERF_CNT_EN
    if (rst) exp_cnt = 16'h0000;
`endif
    exp_q.push_back({e, exp_cnt});
    id_q.push_back(vec_no);
    vec_no++;
`ifdef HAZARD_PERF_CNT_EN
    if (e[0] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`endif
  endtask

  // monitor / scoreboard
  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      logic [22:0] exp_v, act_v;
      int          vid;
      exp_v = exp_q.pop_front();
      vid   = id_q.pop_front();
      act_v = {PCWrite, IFID_Write, IFID_flush, IDEX_bubble, muldiv_start,
               muldiv_busy, stall_out, stall_count};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL vec%0d ctrl got=%b cnt got=%h exp ctrl=%b cnt=%h",
                 vid, act_v[22:16], act_v[15:0], exp_v[22:16], exp_v[15:0]);
      end
    end
  end

  initial begin
    // reset state
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, RSTO);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
    // load-use on rs, then release
    vec(0, 5, 0, 0, 0, 0, 1, 5, 0, LUST);
    vec(0, 5, 0, 0, 0, 0, 0, 5, 0, NORM);
    // load to $zero never stalls
    vec(0, 0, 0, 0, 0, 0, 1, 0, 0, NORM);
    // rt only matters when used
    vec(0, 3, 7, 0, 0, 0, 1, 7, 0, NORM);
    vec(0, 3, 7, 1, 0, 0, 1, 7, 0, LUST);
    // muldiv then dependent mfhi: stall 4 cycles, proceed on 5th
    vec(0, 0, 0, 0, 1, 0, 0, 0, 0, STRT);
    for (int i = 0; i < 4; i++) vec(0, 0, 0, 0, 0, 1, 0, 0, 0, HHST);
    vec(0, 0, 0, 0, 0, 1, 0, 0, 0, NORM);
    // flush beats load-use; no muldiv launch during flush
    vec(0, 5, 0, 0, 0, 0, 1, 5, 1, FLSH);
    vec(0, 0, 0, 0, 1, 0, 0, 0, 1, FLSH);
    // flush beats hh; occupancy drains through it; reset at mdcnt=3
    vec(0, 0, 0, 0, 1, 0, 0, 0, 0, STRT);
    vec(0, 0, 0, 0, 0, 1, 0, 0, 1, FLBZ);
    vec(1, 0, 0, 0, 0, 0, 0, 0, 0, RSTO);
    vec(0, 0, 0, 0, 0, 1, 0, 0, 0, NORM);
    // drain across two flushes then two hh stalls
    vec(0, 0, 0, 0, 1, 0, 0, 0, 0, STRT);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 1, FLBZ);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 1, FLBZ);
    vec(0, 0, 0, 0, 0, 1, 0, 0, 0, HHST);
    vec(0, 0, 0, 0, 0, 1, 0, 0, 0, HHST);
    vec(0, 0, 0, 0, 0, 1, 0, 0, 0, NORM);
    // back-to-back muldiv stalls on occupancy
    vec(0, 0, 0, 0, 1, 0, 0, 0, 0, STRT);
    vec(0, 0, 0, 0, 1, 0, 0, 0, 0, HHST);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, NRBZ);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, NRBZ);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, NRBZ);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
`ifdef HAZARD_PERF_CNT_EN
    // saturation: hold a load-use match well past 16'hFFFF stall cycles
    for (int i = 0; i < 65545; i++) vec(0, 9, 0, 0, 0, 0, 1, 9, 0, LUST);
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
`endif
    vec(0, 0, 0, 0, 0, 0, 0, 0, 0, NORM);
    // bounded drain of the scoreboard
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
